// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with one primary and one skid entry.
// All outputs come straight from registers, so downstream stalls never reach upstream combinationally.
module pipe_stage_skid #(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       count
);

    // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, main_data_next;
    logic [WIDTH-1:0] skid_data_reg, skid_data_next;
    logic             main_valid, skid_valid;
    logic             in_fire, out_fire;

    assign main_valid = state_reg[0];
    assign skid_valid = state_reg[1];

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data_reg;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            // Squash: any out_fire this cycle was already taken downstream.
            state_next = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_data_next = '0;
                skid_data_next = '0;
            end
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_next = in_data;
                        state_next     = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_next = in_data;
                    end else if (in_fire) begin
                        skid_data_next = in_data;
                        state_next     = FULL;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the skid entry can advance.
                    if (out_fire) begin
                        main_data_next = skid_data_reg;
                        state_next     = BUSY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            if (CLEAR_ON_FLUSH) begin
                skid_data_reg <= '0;
            end
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skid_data_reg <= skid_data_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks of pipe_stage_skid: a 32-bit clearing instance
// for directed scenarios and a 97-bit non-clearing instance for randomised traffic.
module tb_pipe_stage_skid;

    logic clk;
    int   vectors;
    int   miscompares;

    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [96:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

    pipe_stage_skid #(.WIDTH(32), .CLEAR_ON_FLUSH(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush), .count(a_count)
    );

    pipe_stage_skid #(.WIDTH(97), .CLEAR_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then sample 1 time unit later; also checks the unreachable state.
    task automatic tick();
        @(posedge clk);
        #1;
        vectors++;
        if ((dut_a.skid_valid && !dut_a.main_valid) || (dut_b.skid_valid && !dut_b.main_valid)) begin
            miscompares++;
            $display("FAIL invalid_state a=%b%b b=%b%b required no skid without main",
                     dut_a.skid_valid, dut_a.main_valid, dut_b.skid_valid, dut_b.main_valid);
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        tick();
        tick();
        a_rst = 1'b0; b_rst = 1'b0; a_in_valid = 1'b0;
        vectors += 4;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
        if (a_count !== 2'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", a_count); end
        if (a_out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", a_out_data); end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        a_out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'(i);
            tick();
            vectors += 4;
            if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid beat %0d got %b want 1", i, a_out_valid); end
            if (a_out_data !== 32'(i)) begin miscompares++; $display("FAIL stream_data beat %0d got %h want %h", i, a_out_data, 32'(i)); end
            if (a_count !== 2'd1) begin miscompares++; $display("FAIL stream_count beat %0d got %0d want 1", i, a_count); end
            if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready beat %0d got %b want 1", i, a_in_ready); end
            $display("stream beat %0d out_data=%h", i, a_out_data);
        end
        a_in_valid = 1'b0;
        tick();
        vectors += 2;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain_valid got %b want 0", a_out_valid); end
        if (a_count !== 2'd0) begin miscompares++; $display("FAIL stream_drain_count got %0d want 0", a_count); end
    endtask

    task automatic test_stall_skid();
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hA;
        tick();
        a_out_ready = 1'b0; a_in_data = 32'hB;
        tick();
        vectors += 3;
        if (a_count !== 2'd2) begin miscompares++; $display("FAIL skid_count got %0d want 2", a_count); end
        if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready got %b want 0", a_in_ready); end
        if (a_out_data !== 32'hA) begin miscompares++; $display("FAIL skid_head got %h want a", a_out_data); end
        a_in_data = 32'hC;
        tick();
        vectors += 3;
        if (a_count !== 2'd2) begin miscompares++; $display("FAIL skid_hold_count got %0d want 2", a_count); end
        if (a_in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_hold_ready got %b want 0", a_in_ready); end
        if (a_out_data !== 32'hA) begin miscompares++; $display("FAIL skid_stable got %h want a", a_out_data); end
        a_out_ready = 1'b1;
        tick();
        vectors += 3;
        if (a_out_data !== 32'hB) begin miscompares++; $display("FAIL drain_b got %h want b", a_out_data); end
        if (a_count !== 2'd1) begin miscompares++; $display("FAIL drain_b_count got %0d want 1", a_count); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_b_ready got %b want 1", a_in_ready); end
        tick();
        a_in_valid = 1'b0;
        vectors += 2;
        if (a_out_data !== 32'hC) begin miscompares++; $display("FAIL drain_c got %h want c", a_out_data); end
        if (a_count !== 2'd1) begin miscompares++; $display("FAIL drain_c_count got %0d want 1", a_count); end
        tick();
        vectors++;
        if (a_count !== 2'd0) begin miscompares++; $display("FAIL drain_empty_count got %0d want 0", a_count); end
        $display("test_stall_skid done");
    endtask

    task automatic test_flush_full();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h11;
        tick();
        a_in_data = 32'h22;
        tick();
        vectors++;
        if (a_count !== 2'd2) begin miscompares++; $display("FAIL flush_pre_count got %0d want 2", a_count); end
        a_flush = 1'b1; a_in_data = 32'h33;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        vectors += 4;
        if (a_count !== 2'd0) begin miscompares++; $display("FAIL flush_count got %0d want 0", a_count); end
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", a_out_valid); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", a_in_ready); end
        if (a_out_data !== 32'h0) begin miscompares++; $display("FAIL flush_data got %h want 0", a_out_data); end
        tick();
        vectors++;
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got valid=%b data=%h want no beat", a_out_valid, a_out_data); end
        // Flush from BUSY while both handshakes fire: still ends EMPTY.
        a_in_valid = 1'b1; a_in_data = 32'h44; a_out_ready = 1'b1;
        tick();
        a_flush = 1'b1; a_in_data = 32'h55;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        vectors += 2;
        if (a_count !== 2'd0) begin miscompares++; $display("FAIL flush_busy_count got %0d want 0", a_count); end
        if (a_out_data !== 32'h0) begin miscompares++; $display("FAIL flush_busy_data got %h want 0", a_out_data); end
        $display("test_flush_full done");
    endtask

    task automatic test_reset_mid_full();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h66;
        tick();
        a_in_data = 32'h77;
        tick();
        vectors++;
        if (a_count !== 2'd2) begin miscompares++; $display("FAIL rstfull_pre_count got %0d want 2", a_count); end
        a_rst = 1'b1; a_flush = 1'b1; a_in_data = 32'h88;
        tick();
        a_rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0;
        vectors += 4;
        if (a_count !== 2'd0) begin miscompares++; $display("FAIL rstfull_count got %0d want 0", a_count); end
        if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rstfull_valid got %b want 0", a_out_valid); end
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL rstfull_ready got %b want 1", a_in_ready); end
        if (a_out_data !== 32'h0) begin miscompares++; $display("FAIL rstfull_data got %h want 0", a_out_data); end
        a_in_valid = 1'b1; a_in_data = 32'h99; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        vectors += 3;
        if (a_out_valid !== 1'b1) begin miscompares++; $display("FAIL rstfull_first_valid got %b want 1", a_out_valid); end
        if (a_out_data !== 32'h99) begin miscompares++; $display("FAIL rstfull_first_data got %h want 99", a_out_data); end
        if (a_count !== 2'd1) begin miscompares++; $display("FAIL rstfull_first_count got %0d want 1", a_count); end
        $display("test_reset_mid_full done");
    endtask

    task automatic test_random_scoreboard();
        logic [96:0]  q[$];
        logic [127:0] r;
        logic         in_fire, out_fire, prev_stall;
        logic [96:0]  prev_data;
        int           beats;
        prev_stall = 1'b0;
        prev_data  = '0;
        beats      = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            b_in_valid  = r[0];
            b_out_ready = r[1];
            b_flush     = (r[9:4] == 6'd0);
            b_in_data   = r[127:31];
            in_fire  = b_in_valid & b_in_ready;
            out_fire = b_out_valid & b_out_ready;
            if (out_fire) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_spurious cyc %0d got %h want no beat", cyc, b_out_data);
                end else begin
                    if (b_out_data !== q[0]) begin
                        miscompares++;
                        $display("FAIL rand_data cyc %0d got %h want %h", cyc, b_out_data, q[0]);
                    end
                    void'(q.pop_front());
                end
                beats++;
                $display("rand beat %0d cyc %0d out_data=%h", beats, cyc, b_out_data);
            end
            if (b_flush) begin
                q.delete();
            end else if (in_fire) begin
                q.push_back(b_in_data);
            end
            prev_stall = b_out_valid & ~b_out_ready & ~b_flush;
            prev_data  = b_out_data;
            tick();
            vectors += 2;
            if (prev_stall && (b_out_data !== prev_data)) begin
                miscompares++;
                $display("FAIL rand_stable cyc %0d got %h want %h", cyc, b_out_data, prev_data);
            end
            if (b_count !== 2'(q.size()) || b_out_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL rand_count cyc %0d got count=%0d valid=%b want %0d", cyc, b_count, b_out_valid, q.size());
            end
        end
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        $display("test_random_scoreboard done beats=%0d", beats);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_reset_mid_full();
        test_random_scoreboard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
